// File: rtl/fc_weight_addrgen_mp_pkg.sv
// Shared state encoding and elaboration-time helpers for the FC weight address generator.
package fc_addrgen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Ceiling log2 for elaboration-time width sizing; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        longint unsigned v;
        r = 0;
        v = 1;
        while (v < longint'(n)) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

    // Guards against zero-width vectors when a range collapses to one value.
    function automatic int unsigned max1(input int unsigned n);
        return (n == 0) ? 1 : n;
    endfunction

endpackage

// File: rtl/fc_weight_addrgen_mp_wrap_counter.sv
// Counter advancing by STEP that returns to 0 after reaching MODULUS-STEP.
module fc_wrap_counter
    import fc_addrgen_pkg::*;
#(
    parameter int unsigned STEP    = 1,
    parameter int unsigned MODULUS = 2,
    parameter int unsigned WIDTH   = max1(clog2(MODULUS))
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o,
    output logic             at_last_c
);

    localparam int unsigned LAST = MODULUS - STEP;

    if ((STEP == 0) || (MODULUS < STEP) || ((MODULUS % STEP) != 0)) begin : g_bad_params
        $fatal(1, "fc_wrap_counter: MODULUS must be a non-zero multiple of STEP");
    end

    logic [WIDTH-1:0] count_q, count_d;

    assign count_o   = count_q;
    assign at_last_c = (count_q == WIDTH'(LAST));

    // Next count: clear wins, otherwise step or wrap to zero.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = at_last_c ? '0 : count_q + WIDTH'(STEP);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fc_weight_addrgen_mp.sv
// Multi-port weight-memory address generator for a fully connected layer.
module fc_weight_addrgen_mp
    import fc_addrgen_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned OUTNEURON  = 10,
    parameter int unsigned INNEURON   = 20,
    parameter int unsigned PO         = 2,
    parameter int unsigned NPORT      = 2
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      start,
    input  logic                                      mode,
    input  logic                                      enable,
    input  logic                                      stop,
    output logic [NPORT*ADDR_WIDTH-1:0]               addr,
    output logic                                      addr_valid,
    output logic [max1(clog2(OUTNEURON/PO))-1:0]      grp_idx,
    output logic                                      grp_end,
    output logic                                      pass_end,
    output logic                                      busy,
    output logic                                      done
);

    localparam int unsigned AW        = ADDR_WIDTH;
    localparam int unsigned NGRP      = OUTNEURON / PO;
    localparam int unsigned DEPTH     = NGRP * INNEURON;
    localparam int unsigned BEATS_GRP = INNEURON / NPORT;
    localparam int unsigned GRP_W     = max1(clog2(NGRP));
    localparam int unsigned BEAT_W    = max1(clog2(BEATS_GRP));

    if (((OUTNEURON % PO) != 0) || ((INNEURON % NPORT) != 0) ||
        (NPORT < 2) || (NPORT > 8) ||
        (64'(DEPTH) > (64'd1 << ADDR_WIDTH))) begin : g_bad_params
        $fatal(1, "fc_weight_addrgen_mp: illegal parameter combination");
    end

    state_e                  state_q, state_d;
    logic                    mode_q, mode_d;
    logic [GRP_W-1:0]        grp_cnt_q, grp_cnt_d;
    logic [NPORT*AW-1:0]     addr_q, addr_d;
    logic                    addr_valid_q, addr_valid_d;
    logic [GRP_W-1:0]        grp_idx_q, grp_idx_d;
    logic                    grp_end_q, grp_end_d;
    logic                    pass_end_q, pass_end_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic                    accept_c;
    logic                    clr_c;
    logic [AW-1:0]           base_cnt;
    logic                    base_last_c;
    logic [BEAT_W-1:0]       beat_idx_unused;
    logic                    beat_last_c;

    // A beat is taken only in RUN with permission and no abort pending.
    assign accept_c = (state_q == ST_RUN) && enable && !stop;
    // Counters sit at zero whenever not actively running, and on abort.
    assign clr_c    = (state_q != ST_RUN) || stop;

    // Beat base address B, stepping by the port count across the whole pass.
    fc_wrap_counter #(
        .STEP    (NPORT),
        .MODULUS (DEPTH),
        .WIDTH   (AW)
    ) u_base_cnt (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (clr_c),
        .inc_i     (accept_c),
        .count_o   (base_cnt),
        .at_last_c (base_last_c)
    );

    // Beat position within the current output-neuron group.
    fc_wrap_counter #(
        .STEP    (1),
        .MODULUS (BEATS_GRP),
        .WIDTH   (BEAT_W)
    ) u_beat_cnt (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (clr_c),
        .inc_i     (accept_c),
        .count_o   (beat_idx_unused),
        .at_last_c (beat_last_c)
    );

    // Next-state logic plus next values for the registered outputs.
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        grp_cnt_d    = grp_cnt_q;
        addr_d       = addr_q;
        addr_valid_d = accept_c;
        grp_idx_d    = grp_idx_q;
        grp_end_d    = accept_c && beat_last_c;
        pass_end_d   = accept_c && base_last_c;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    mode_d  = mode;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (accept_c && base_last_c && !mode_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (clr_c) begin
            grp_cnt_d = '0;
        end else if (accept_c && beat_last_c) begin
            grp_cnt_d = base_last_c ? '0 : grp_cnt_q + GRP_W'(1);
        end

        if (accept_c) begin
            for (int unsigned k = 0; k < NPORT; k++) begin
                addr_d[k*AW +: AW] = base_cnt + AW'(k);
            end
            grp_idx_d = grp_cnt_q;
        end

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State, group counter and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            mode_q       <= 1'b0;
            grp_cnt_q    <= '0;
            addr_q       <= '0;
            addr_valid_q <= 1'b0;
            grp_idx_q    <= '0;
            grp_end_q    <= 1'b0;
            pass_end_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            grp_cnt_q    <= grp_cnt_d;
            addr_q       <= addr_d;
            addr_valid_q <= addr_valid_d;
            grp_idx_q    <= grp_idx_d;
            grp_end_q    <= grp_end_d;
            pass_end_q   <= pass_end_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign addr       = addr_q;
    assign addr_valid = addr_valid_q;
    assign grp_idx    = grp_idx_q;
    assign grp_end    = grp_end_q;
    assign pass_end   = pass_end_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_fc_weight_addrgen_mp.sv
// Scoreboard bench: a 2-port and a 4-port generator over a 100-word weight memory.
module tb_fc_weight_addrgen_mp;

    localparam int AW    = 10;
    localparam int IN    = 20;
    localparam int DEPTH = 100;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] grp;
        logic        gend;
        logic        pend;
    } beat_t;

    logic clk;
    logic reset;

    logic          start_a, mode_a, enable_a, stop_a;
    logic [2*AW-1:0] addr_a;
    logic          addr_valid_a, grp_end_a, pass_end_a, busy_a, done_a;
    logic [2:0]    grp_idx_a;

    logic          start_b, mode_b, enable_b, stop_b;
    logic [4*AW-1:0] addr_b;
    logic          addr_valid_b, grp_end_b, pass_end_b, busy_b, done_b;
    logic [2:0]    grp_idx_b;

    beat_t qa[$];
    beat_t qb[$];
    int    n_cmp = 0;
    int    n_err = 0;

    fc_weight_addrgen_mp #(
        .ADDR_WIDTH(AW), .OUTNEURON(10), .INNEURON(IN), .PO(2), .NPORT(2)
    ) u_dut_a (
        .clk(clk), .reset(reset), .start(start_a), .mode(mode_a),
        .enable(enable_a), .stop(stop_a), .addr(addr_a), .addr_valid(addr_valid_a),
        .grp_idx(grp_idx_a), .grp_end(grp_end_a), .pass_end(pass_end_a),
        .busy(busy_a), .done(done_a)
    );

    fc_weight_addrgen_mp #(
        .ADDR_WIDTH(AW), .OUTNEURON(10), .INNEURON(IN), .PO(2), .NPORT(4)
    ) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .mode(mode_b),
        .enable(enable_b), .stop(stop_b), .addr(addr_b), .addr_valid(addr_valid_b),
        .grp_idx(grp_idx_b), .grp_end(grp_end_b), .pass_end(pass_end_b),
        .busy(busy_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected beat with base b for an np-port generator, derived arithmetically.
    function automatic beat_t mk(input int b, input int np);
        beat_t e;
        e.addr = '0;
        for (int k = 0; k < np; k++) begin
            e.addr[k*AW +: AW] = AW'(b + k);
        end
        e.grp  = 64'(b / IN);
        e.gend = (((b + np) % IN) == 0);
        e.pend = ((b + np) == DEPTH);
        return e;
    endfunction

    // Pop and compare every presented beat of the 2-port generator.
    always @(negedge clk) begin
        beat_t e;
        if (!reset && addr_valid_a) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_beat", 64'(addr_valid_a), 64'd0);
            end else begin
                e = qa.pop_front();
                chk("a_addr", 64'(addr_a), e.addr);
                chk("a_grp_idx", 64'(grp_idx_a), e.grp);
                chk("a_grp_end", 64'(grp_end_a), 64'(e.gend));
                chk("a_pass_end", 64'(pass_end_a), 64'(e.pend));
            end
        end
    end

    // Pop and compare every presented beat of the 4-port generator.
    always @(negedge clk) begin
        beat_t e;
        if (!reset && addr_valid_b) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_beat", 64'(addr_valid_b), 64'd0);
            end else begin
                e = qb.pop_front();
                chk("b_addr", 64'(addr_b), e.addr);
                chk("b_grp_idx", 64'(grp_idx_b), e.grp);
                chk("b_grp_end", 64'(grp_end_b), 64'(e.gend));
                chk("b_pass_end", 64'(pass_end_b), 64'(e.pend));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drain_a();
        for (int i = 0; i < 4 && qa.size() != 0; i++) cyc();
        chk("a_queue_drain", 64'(qa.size()), 64'd0);
    endtask

    task automatic drain_b();
        for (int i = 0; i < 4 && qb.size() != 0; i++) cyc();
        chk("b_queue_drain", 64'(qb.size()), 64'd0);
    endtask

    // One full single pass of the 2-port generator with enable held high.
    task automatic run_single_a();
        start_a  = 1'b1;
        mode_a   = 1'b0;
        enable_a = 1'b1;
        cyc();
        start_a = 1'b0;
        stop_a  = 1'b0;
        chk("a_busy_run", 64'(busy_a), 64'd1);
        for (int i = 0; i < 50; i++) begin
            qa.push_back(mk(2 * i, 2));
            cyc();
        end
        chk("a_done_pulse", 64'(done_a), 64'd1);
        chk("a_busy_in_done", 64'(busy_a), 64'd0);
        cyc();
        chk("a_done_clear", 64'(done_a), 64'd0);
        chk("a_valid_after_pass", 64'(addr_valid_a), 64'd0);
        drain_a();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout compared=%0d mismatched=%0d", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        beat_t t;
        reset    = 1'b1;
        start_a  = 1'b0; mode_a = 1'b0; enable_a = 1'b0; stop_a = 1'b0;
        start_b  = 1'b0; mode_b = 1'b0; enable_b = 1'b0; stop_b = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_addr", 64'(addr_a), 64'd0);
        chk("rst_valid", 64'(addr_valid_a), 64'd0);
        chk("rst_busy", 64'(busy_a), 64'd0);
        chk("rst_done", 64'(done_a), 64'd0);
        reset = 1'b0;
        cyc();

        // Single pass.
        run_single_a();

        // Continuous mode across the wrap, then stop.
        start_a = 1'b1; mode_a = 1'b1; enable_a = 1'b1;
        cyc();
        start_a = 1'b0;
        for (int i = 0; i < 60; i++) begin
            qa.push_back(mk((2 * i) % DEPTH, 2));
            cyc();
            if (i == 50) begin
                chk("a_cont_no_done", 64'(done_a), 64'd0);
                chk("a_cont_busy", 64'(busy_a), 64'd1);
            end
        end
        stop_a = 1'b1;
        cyc();
        stop_a = 1'b0;
        chk("a_cont_stop_busy", 64'(busy_a), 64'd0);
        chk("a_cont_stop_valid", 64'(addr_valid_a), 64'd0);
        cyc();
        chk("a_cont_stop_done", 64'(done_a), 64'd0);
        drain_a();

        // Enable toggling every cycle.
        start_a = 1'b1; mode_a = 1'b0; enable_a = 1'b1;
        cyc();
        start_a = 1'b0;
        for (int j = 0; j < 50; j++) begin
            enable_a = 1'b1;
            qa.push_back(mk(2 * j, 2));
            cyc();
            if (j < 49) begin
                enable_a = 1'b0;
                cyc();
                t = mk(2 * j, 2);
                chk("a_stall_valid", 64'(addr_valid_a), 64'd0);
                chk("a_stall_hold", 64'(addr_a), t.addr);
            end
        end
        chk("a_toggle_done", 64'(done_a), 64'd1);
        enable_a = 1'b1;
        cyc();
        drain_a();

        // Stop after 30 beats, then start together with stop in IDLE.
        start_a = 1'b1; mode_a = 1'b0; enable_a = 1'b1;
        cyc();
        start_a = 1'b0;
        for (int i = 0; i < 30; i++) begin
            qa.push_back(mk(2 * i, 2));
            cyc();
        end
        stop_a = 1'b1;
        cyc();
        stop_a = 1'b0;
        chk("a_stop_busy", 64'(busy_a), 64'd0);
        chk("a_stop_valid", 64'(addr_valid_a), 64'd0);
        chk("a_stop_done", 64'(done_a), 64'd0);
        cyc();
        chk("a_stop_done_later", 64'(done_a), 64'd0);
        drain_a();
        stop_a = 1'b1;
        run_single_a();

        // Reset in the middle of a pass.
        start_a = 1'b1; mode_a = 1'b0; enable_a = 1'b1;
        cyc();
        start_a = 1'b0;
        for (int i = 0; i < 20; i++) begin
            qa.push_back(mk(2 * i, 2));
            cyc();
        end
        enable_a = 1'b0;
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("a_mid_rst_addr", 64'(addr_a), 64'd0);
        chk("a_mid_rst_valid", 64'(addr_valid_a), 64'd0);
        chk("a_mid_rst_grp", 64'(grp_idx_a), 64'd0);
        chk("a_mid_rst_busy", 64'(busy_a), 64'd0);
        chk("a_mid_rst_queue", 64'(qa.size()), 64'd0);
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("a_post_rst_done", 64'(done_a), 64'd0);
        end
        run_single_a();

        // Four-port build: 25 beats per pass.
        start_b = 1'b1; mode_b = 1'b0; enable_b = 1'b1;
        cyc();
        start_b = 1'b0;
        for (int i = 0; i < 25; i++) begin
            qb.push_back(mk(4 * i, 4));
            cyc();
        end
        chk("b_done_pulse", 64'(done_b), 64'd1);
        cyc();
        chk("b_done_clear", 64'(done_b), 64'd0);
        drain_b();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
